// File: rtl/ws2812_frame_driver_if.sv
// Pixel request/response link between the WS2812 frame driver (master) and the cell engine
// (slave): the driver drives the pixel index, the engine answers with its intensity.
interface ws2812_frame_driver_if;
  logic [5:0] pixel;
  logic [7:0] read_data;

  modport master (output pixel, input read_data);
  modport slave  (input pixel, output read_data);
endinterface

// File: rtl/ws2812_frame_driver.sv
// Walks every pixel of the 8x8 display, fetches its intensity from the cell engine and streams
// it as 24-bit GRB words on a single WS2812 line, then latches and advances the generation.
module ws2812_frame_driver #(
  parameter int unsigned NUM_PIXELS   = 64,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned CHANNEL      = 0,
  parameter int unsigned T0H          = 4,
  parameter int unsigned T1H          = 8,
  parameter int unsigned TBIT         = 15,
  parameter int unsigned RESET_CYCLES = 1000,
  parameter int unsigned FRAME_GAP    = 12000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable_i,
  ws2812_frame_driver_if.master        pix_if,
  output logic                         dout_o,
  output logic                         state_update_o,
  output logic                         frame_done_o,
  output logic                         busy_o
);

  localparam int unsigned MaxA   = (RESET_CYCLES > FRAME_GAP) ? RESET_CYCLES : FRAME_GAP;
  localparam int unsigned MaxB   = (TBIT > READ_LATENCY + 1) ? TBIT : READ_LATENCY + 1;
  localparam int unsigned CntMax = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned LaneShift = 8 * (2 - CHANNEL);

  localparam logic [CntW-1:0] CntOne     = CntW'(1);
  localparam logic [CntW-1:0] FetchLast  = CntW'(READ_LATENCY);
  localparam logic [CntW-1:0] BitLast    = CntW'(TBIT - 1);
  localparam logic [CntW-1:0] LatchLast  = CntW'(RESET_CYCLES - 1);
  localparam logic [CntW-1:0] LatchPulse = CntW'(RESET_CYCLES - 2);
  localparam logic [CntW-1:0] GapLast    = CntW'(FRAME_GAP - 1);
  localparam logic [CntW-1:0] T0hC       = CntW'(T0H);
  localparam logic [CntW-1:0] T1hC       = CntW'(T1H);
  localparam logic [5:0]      PixLast    = 6'(NUM_PIXELS - 1);

  typedef enum logic [2:0] {StIdle, StFetch, StShift, StLatch, StGap} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [4:0]      bit_q;
  logic [23:0]     word_q;
  logic [5:0]      pixel_q;
  logic            dout_q;
  logic            su_q;
  logic            busy_q;
  logic [CntW-1:0] high_len;

  function automatic logic [23:0] lane(input logic [7:0] d);
    return {16'h0000, d} << LaneShift;
  endfunction

  assign high_len = word_q[bit_q] ? T1hC : T0hC;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      word_q  <= '0;
      pixel_q <= '0;
      dout_q  <= 1'b0;
      su_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      su_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          dout_q <= 1'b0;
          if (enable_i) begin
            state_q <= StFetch;
            pixel_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        StFetch: begin
          if (cnt_q == FetchLast) begin
            word_q  <= lane(pix_if.read_data);
            bit_q   <= 5'd23;
            cnt_q   <= '0;
            dout_q  <= 1'b1;  // every bit period opens high
            state_q <= StShift;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StShift: begin
          if (cnt_q == BitLast) begin
            cnt_q <= '0;
            if (bit_q == 5'd0) begin
              dout_q <= 1'b0;
              if (pixel_q == PixLast) begin
                state_q <= StLatch;
                su_q    <= (RESET_CYCLES == 32'd1);
              end else begin
                pixel_q <= pixel_q + 6'd1;
                state_q <= StFetch;
              end
            end else begin
              bit_q  <= bit_q - 5'd1;
              dout_q <= 1'b1;
            end
          end else begin
            cnt_q  <= cnt_q + CntOne;
            dout_q <= (cnt_q + CntOne) < high_len;
          end
        end
        StLatch: begin
          if (cnt_q == LatchLast) begin
            cnt_q   <= '0;
            pixel_q <= '0;
            state_q <= StGap;
          end else begin
            cnt_q <= cnt_q + CntOne;
            // Pulse lands on the final latch cycle.
            su_q  <= (cnt_q == LatchPulse);
          end
        end
        StGap: begin
          if (cnt_q == GapLast) begin
            cnt_q <= '0;
            if (enable_i) begin
              state_q <= StFetch;
              pixel_q <= '0;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pix_if.pixel   = pixel_q;
  assign dout_o         = dout_q;
  assign state_update_o = su_q;
  assign frame_done_o   = su_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_ws2812_frame_driver.sv
// Drives two driver instances (default timing, and a fast CHANNEL=1 variant) against a
// waveform reference built from per-pixel intensities and the WS2812 timing rules.
module tb_ws2812_frame_driver;

  localparam int RL_A = 2;
  localparam int RL_B = 3;

  logic clk = 1'b0;
  logic rst_a, rst_b, en_a, en_b;
  logic dout_a, su_a, fd_a, busy_a;
  logic dout_b, su_b, fd_b, busy_b;

  ws2812_frame_driver_if if_a ();
  ws2812_frame_driver_if if_b ();

  ws2812_frame_driver u_dut_a (
    .clk            (clk),
    .rst            (rst_a),
    .enable_i       (en_a),
    .pix_if         (if_a),
    .dout_o         (dout_a),
    .state_update_o (su_a),
    .frame_done_o   (fd_a),
    .busy_o         (busy_a)
  );

  ws2812_frame_driver #(
    .NUM_PIXELS   (64),
    .READ_LATENCY (RL_B),
    .CHANNEL      (1),
    .T0H          (2),
    .T1H          (5),
    .TBIT         (7),
    .RESET_CYCLES (20),
    .FRAME_GAP    (30)
  ) u_dut_b (
    .clk            (clk),
    .rst            (rst_b),
    .enable_i       (en_b),
    .pix_if         (if_b),
    .dout_o         (dout_b),
    .state_update_o (su_b),
    .frame_done_o   (fd_b),
    .busy_o         (busy_b)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;

  logic [7:0] mem_a [64];
  logic [7:0] mem_b [64];
  logic [5:0] last_a = '0, last_b = '0;
  int age_a = 0, age_b = 0;

  // Cell engine: data becomes valid READ_LATENCY cycles after a pixel change, noise before.
  always @(negedge clk) begin
    if (if_a.pixel != last_a) age_a = 0; else if (age_a < 1000) age_a++;
    last_a = if_a.pixel;
    if_a.read_data = (age_a >= RL_A) ? mem_a[if_a.pixel] : 8'($urandom);
    if (if_b.pixel != last_b) age_b = 0; else if (age_b < 1000) age_b++;
    last_b = if_b.pixel;
    if_b.read_data = (age_b >= RL_B) ? mem_b[if_b.pixel] : 8'($urandom);
  end

  bit sel = 1'b0;
  logic m_dout, m_su, m_fd, m_busy;
  logic [5:0] m_pixel;
  assign m_dout  = sel ? dout_b : dout_a;
  assign m_su    = sel ? su_b : su_a;
  assign m_fd    = sel ? fd_b : fd_a;
  assign m_busy  = sel ? busy_b : busy_a;
  assign m_pixel = sel ? if_b.pixel : if_a.pixel;

  int npx, rl, ch, t0h, t1h, tbit, rstc, gap;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_params(input bit s);
    sel = s;
    npx = 64;
    if (!s) begin
      rl = RL_A; ch = 0; t0h = 4; t1h = 8; tbit = 15; rstc = 1000; gap = 12000;
    end else begin
      rl = RL_B; ch = 1; t0h = 2; t1h = 5; tbit = 7; rstc = 20; gap = 30;
    end
  endtask

  // Entered at the first FETCH cycle of pixel 0; leaves at the first cycle after the gap.
  task automatic run_frame(input bit restart, input int drop_px);
    int errs;
    int pulses;
    logic [7:0] d;
    logic [23:0] w;
    for (int p = 0; p < npx; p++) begin
      errs = 0;
      if (p == drop_px) begin
        if (sel) en_b = 1'b0; else en_a = 1'b0;
      end
      check_eq("fetch_pixel", 32'(m_pixel), p);
      d = sel ? mem_b[p] : mem_a[p];
      w = {(ch == 0) ? d : 8'h00, (ch == 1) ? d : 8'h00, (ch == 2) ? d : 8'h00};
      for (int k = 0; k <= rl; k++) begin
        if (m_dout !== 1'b0 || m_busy !== 1'b1 || m_pixel !== p[5:0] || m_su !== 1'b0) errs++;
        @(negedge clk);
      end
      for (int b = 23; b >= 0; b--) begin
        for (int k = 0; k < tbit; k++) begin
          if (m_dout !== (k < (w[b] ? t1h : t0h))) errs++;
          if (m_busy !== 1'b1 || m_pixel !== p[5:0] || m_su !== 1'b0 || m_fd !== 1'b0) errs++;
          @(negedge clk);
        end
      end
      check_eq("pixel_wave", errs, 0);
    end
    errs = 0;
    pulses = 0;
    for (int k = 0; k < rstc; k++) begin
      if (m_dout !== 1'b0 || m_busy !== 1'b1) errs++;
      if (m_su === 1'b1) pulses++;
      if (m_su !== (k == rstc - 1) || m_fd !== (k == rstc - 1)) errs++;
      @(negedge clk);
    end
    check_eq("latch_wave", errs, 0);
    check_eq("su_pulses", pulses, 1);
    errs = 0;
    for (int k = 0; k < gap; k++) begin
      if (m_dout !== 1'b0 || m_busy !== 1'b1 || m_pixel !== 6'd0) errs++;
      if (m_su !== 1'b0 || m_fd !== 1'b0) errs++;
      @(negedge clk);
    end
    check_eq("gap_wave", errs, 0);
    check_eq("next_busy", 32'(m_busy), restart ? 1 : 0);
    check_eq("next_pixel", 32'(m_pixel), 0);
    check_eq("next_dout", 32'(m_dout), 0);
  endtask

  initial begin
    int errs;
    int su_seen;
    bit found;
    rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b1; en_b = 1'b1;
    for (int p = 0; p < 64; p++) begin
      mem_a[p] = 8'($urandom);
      mem_b[p] = 8'($urandom);
    end
    mem_a[0] = 8'hFF;
    mem_b[0] = 8'h4F;
    mem_b[1] = 8'h00;
    set_params(1'b0);
    repeat (3) @(negedge clk);

    check_eq("rst_dout", 32'(dout_a), 0);
    check_eq("rst_pixel", 32'(if_a.pixel), 0);
    check_eq("rst_busy", 32'(busy_a), 0);
    check_eq("rst_pulses", 32'({su_a, fd_a, su_b, fd_b}), 0);
    check_eq("rst_busy_b", 32'(busy_b), 0);

    rst_a = 1'b0;
    @(negedge clk);
    check_eq("rel_busy", 32'(busy_a), 1);
    run_frame(1'b1, -1);
    rst_a = 1'b1;

    set_params(1'b1);
    rst_b = 1'b0;
    @(negedge clk);
    run_frame(1'b0, 30);
    errs = 0;
    for (int k = 0; k < 20; k++) begin
      if (busy_b !== 1'b0 || dout_b !== 1'b0 || su_b !== 1'b0) errs++;
      @(negedge clk);
    end
    check_eq("idle_hold", errs, 0);

    en_b = 1'b1;
    @(negedge clk);
    su_seen = 0;
    found = 1'b0;
    for (int k = 0; k < 20000 && !found; k++) begin
      if (su_b === 1'b1) su_seen++;
      if (if_b.pixel == 6'd40 && dout_b === 1'b1) found = 1'b1;
      else @(negedge clk);
    end
    check_eq("reach_px40", 32'(found), 1);
    rst_b = 1'b1;
    #1;
    check_eq("abort_dout", 32'(dout_b), 0);
    check_eq("abort_pixel", 32'(if_b.pixel), 0);
    check_eq("abort_busy", 32'(busy_b), 0);
    en_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (su_b === 1'b1) su_seen++;
      @(negedge clk);
    end
    check_eq("abort_no_su", su_seen, 0);
    check_eq("abort_idle", 32'(busy_b), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
